// File: rtl/divider_if.sv
// -----------------------------------------------------------------------------
// divider_if : request/result bundle for the sequential divider
//
//   en        master -> slave  enable; low freezes the divider
//   start     master -> slave  division request
//   dividend  master -> slave  2*WIDTH-bit numerator
//   divisor   master -> slave  WIDTH-bit denominator
//   quotient  slave -> master  WIDTH-bit result
//   remainder slave -> master  WIDTH-bit remainder
//   busy      slave -> master  operation in progress
//   ready     slave -> master  quotient/remainder valid
//   err       slave -> master  result invalid (divide-by-zero / overflow)
// -----------------------------------------------------------------------------
interface divider_if #(
   parameter int WIDTH = 16
);
   logic                 en;
   logic                 start;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 busy;
   logic                 ready;
   logic                 err;

   modport master (
      output en, start, dividend, divisor,
      input  quotient, remainder, busy, ready, err
   );

   modport slave (
      input  en, start, dividend, divisor,
      output quotient, remainder, busy, ready, err
   );
endinterface

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider : sequential restoring divider, 2*WIDTH / WIDTH, one quotient bit
//           per clock, MSB first.
//
// Ports
//   clk    system clock, rising edge
//   res_n  asynchronous active-low reset
//   bus    divider_if.slave (en, start, dividend, divisor in;
//          quotient, remainder, busy, ready, err out)
//
// Timing: a request accepted on edge 0 keeps busy high for WIDTH cycles and
// lands in DONE on edge WIDTH. Divide-by-zero (and overflow, when checked)
// skips the iterations and finishes on the next edge with a saturated
// quotient and err=1.
//
// Configuration macro: DIVIDER_OVERFLOW_CHECK_EN
//   defined   : a dividend whose high half is >= divisor saturates with err=1.
//   undefined : such a dividend runs normally and the quotient holds the low
//               WIDTH bits of the true quotient.
// -----------------------------------------------------------------------------
module divider #(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     res_n,
   divider_if.slave bus
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   rem_q;      // partial remainder, always < dsr_q
   logic [WIDTH-1:0]   lo_q;       // dividend bits still to be shifted in
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   dsr_q;
   logic               busy_q;
   logic               ready_q;
   logic               err_q;
   logic               sat_q;      // finish next edge with a saturated result

   logic               sat_d;
   logic [WIDTH-1:0]   rem_init_d;
   logic [WIDTH:0]     shifted;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_step;

`ifndef DIVIDER_OVERFLOW_CHECK_EN
   // Reduces the dividend high half modulo the divisor. Starting the
   // iterations from (high mod divisor) makes the WIDTH produced quotient
   // bits equal the low WIDTH bits of the true quotient even when the full
   // quotient does not fit, and keeps the partial remainder below divisor.
   function automatic logic [WIDTH-1:0] mod_high(
      input logic [WIDTH-1:0] u,
      input logic [WIDTH-1:0] d
   );
      logic [WIDTH:0] r;
      r = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         r = {r[WIDTH-1:0], u[i]};
         if (r >= {1'b0, d}) r = r - {1'b0, d};
      end
      return r[WIDTH-1:0];
   endfunction
`endif

   // Operand screening at acceptance time.
   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sat_d      = 1'b0;
      rem_init_d = '0;
`ifdef DIVIDER_OVERFLOW_CHECK_EN
      // Covers divisor == 0 as well: any high half is >= 0.
      sat_d      = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
      rem_init_d = bus.dividend[2*WIDTH-1:WIDTH];
`else
      sat_d      = (bus.divisor == '0);
      if (!sat_d) rem_init_d = mod_high(bus.dividend[2*WIDTH-1:WIDTH], bus.divisor);
`endif
   end

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   always_comb begin
      shifted  = {rem_q, lo_q[WIDTH-1]};
      q_bit    = (shifted >= {1'b0, dsr_q});
      rem_step = q_bit ? WIDTH'(shifted - {1'b0, dsr_q}) : WIDTH'(shifted);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, as real flops do.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         // NOTE: the datapath registers are reset too, because quotient and
         // remainder are driven straight from them and must read zero.
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         lo_q    <= '0;
         quo_q   <= '0;
         dsr_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else if (bus.en) begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q <= BUSY;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
                  sat_q   <= sat_d;
                  rem_q   <= rem_init_d;
                  lo_q    <= bus.dividend[WIDTH-1:0];
                  dsr_q   <= bus.divisor;
                  quo_q   <= '0;
               end
            end
            BUSY: begin
               if (sat_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
                  quo_q   <= '1;
                  rem_q   <= '0;
               end else begin
                  rem_q <= rem_step;
                  lo_q  <= {lo_q[WIDTH-2:0], 1'b0};
                  quo_q <= {quo_q[WIDTH-2:0], q_bit};
                  cnt_q <= cnt_q + 1'b1;
                  // The counter reaches WIDTH on this edge and stops there.
                  if (cnt_q == LAST) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.quotient  = quo_q;
   assign bus.remainder = rem_q;
   assign bus.busy      = busy_q;
   assign bus.ready     = ready_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider : self-checking bench for divider (WIDTH = 16).
// A cycle-level reference model predicts busy/ready/err and the arithmetic
// result; a compare process checks the DUT against it on every falling edge.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_divider;

   localparam int W = 16;

`ifdef DIVIDER_OVERFLOW_CHECK_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic clk;
   logic res_n;
   int   tests;
   int   fails;
   bit   cmp_on;

   divider_if #(.WIDTH(W)) bus ();

   divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_q(input logic [2*W-1:0] n, input logic [W-1:0] d);
      logic [2*W-1:0] t;
      t = n / {{W{1'b0}}, d};
      return t[W-1:0];
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [2*W-1:0] n, input logic [W-1:0] d);
      logic [2*W-1:0] t;
      t = n % {{W{1'b0}}, d};
      return t[W-1:0];
   endfunction

   logic         m_busy, m_ready, m_err, m_rcare;
   logic [W-1:0] m_q, m_r;
   logic         p_err, p_rcare;
   logic [W-1:0] p_q, p_r;
   int           m_left;

   always @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         m_busy  <= 1'b0;
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         m_q     <= '0;
         m_r     <= '0;
         m_rcare <= 1'b1;
         m_left  <= 0;
      end else if (bus.en) begin
         if (bus.start && !m_busy) begin
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            if (bus.divisor == '0 || (OVF && bus.dividend[2*W-1:W] >= bus.divisor)) begin
               m_left  <= 1;
               p_q     <= '1;
               p_r     <= '0;
               p_err   <= 1'b1;
               p_rcare <= 1'b1;
            end else begin
               m_left  <= W;
               p_q     <= ref_q(bus.dividend, bus.divisor);
               p_r     <= ref_r(bus.dividend, bus.divisor);
               p_err   <= 1'b0;
               // remainder is unspecified when the quotient overflows
               p_rcare <= (bus.dividend[2*W-1:W] < bus.divisor);
            end
         end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy  <= 1'b0;
               m_ready <= 1'b1;
               m_err   <= p_err;
               m_q     <= p_q;
               m_r     <= p_r;
               m_rcare <= p_rcare;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_on) begin
         check("cmp_busy",  32'(bus.busy),  32'(m_busy));
         check("cmp_ready", 32'(bus.ready), 32'(m_ready));
         check("cmp_err",   32'(bus.err),   32'(m_err));
         if (m_ready) begin
            check("cmp_quotient", 32'(bus.quotient), 32'(m_q));
            if (m_rcare) check("cmp_remainder", 32'(bus.remainder), 32'(m_r));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Presents a request for one edge, then scrambles the operands so any
   // dependence on post-acceptance inputs shows up. Returns at edge+2.
   task automatic start_op(input logic [2*W-1:0] n, input logic [W-1:0] d);
      @(posedge clk); #2;
      bus.dividend = n;
      bus.divisor  = d;
      bus.start    = 1'b1;
      @(posedge clk); #2;
      bus.start    = 1'b0;
      bus.dividend = ~n;
      bus.divisor  = d ^ 16'h00F0;
   endtask

   // Counts busy cycles until ready rises, bounded.
   task automatic wait_done(output int cycles, output bit seen);
      cycles = 0;
      seen   = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.ready) seen = 1'b1;
         else if (bus.busy) cycles++;
      end
   endtask

   task automatic check_result(input string tag, input int cyc, input bit seen,
                               input int exp_cyc, input logic [W-1:0] exp_q,
                               input logic [W-1:0] exp_r, input logic exp_err,
                               input bit chk_r);
      check({tag, "_ready_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_quotient"}, 32'(bus.quotient), 32'(exp_q));
      if (chk_r) check({tag, "_remainder"}, 32'(bus.remainder), 32'(exp_r));
      check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      bit seen;
      tests = 0;
      fails = 0;
      cmp_on = 1'b0;
      bus.en = 1'b1;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      res_n = 1'b1;
      #1 res_n = 1'b0;
      #1;
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_ready",     32'(bus.ready),     32'd0);
      check("rst_err",       32'(bus.err),       32'd0);
      check("rst_quotient",  32'(bus.quotient),  32'd0);
      check("rst_remainder", 32'(bus.remainder), 32'd0);
      cmp_on = 1'b1;
      repeat (2) @(posedge clk);
      #2 res_n = 1'b1;

      // 1000 / 200
      start_op(32'd1000, 16'd200);
      wait_done(cyc, seen);
      check_result("basic", cyc, seen, 16, 16'd5, 16'd0, 1'b0, 1'b1);

      // 73728 / 255 with an ignored start pulse mid-operation
      start_op(32'd73728, 16'd255);
      fork
         wait_done(cyc, seen);
         begin
            repeat (5) @(posedge clk);
            #2;
            bus.dividend = 32'd9;
            bus.divisor  = 16'd3;
            bus.start    = 1'b1;
            @(posedge clk); #2;
            bus.start    = 1'b0;
         end
      join
      check_result("ignstart", cyc, seen, 16, 16'd289, 16'd33, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("ignstart_hold_busy",  32'(bus.busy),     32'd0);
      check("ignstart_hold_q",     32'(bus.quotient), 32'd289);

      // divide by zero
      start_op(32'd500, 16'd0);
      wait_done(cyc, seen);
      check_result("divzero", cyc, seen, 1, 16'hFFFF, 16'd0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      check("divzero_hold_err", 32'(bus.err), 32'd1);

      // quotient overflow
      start_op(32'h0001_0000, 16'd1);
      wait_done(cyc, seen);
`ifdef DIVIDER_OVERFLOW_CHECK_EN
      check_result("overflow", cyc, seen, 1, 16'hFFFF, 16'd0, 1'b1, 1'b1);
`else
      check_result("overflow", cyc, seen, 16, 16'h0000, 16'd0, 1'b0, 1'b0);
`endif

      // en low for 5 cycles at iteration 8
      start_op(32'd1000, 16'd200);
      fork
         wait_done(cyc, seen);
         begin
            repeat (7) @(posedge clk);
            #2 bus.en = 1'b0;
            repeat (5) @(posedge clk);
            #2 bus.en = 1'b1;
         end
      join
      check_result("enstall", cyc, seen, 21, 16'd5, 16'd0, 1'b0, 1'b1);

      // reset at iteration 10, then no ready until a new request
      start_op(32'd1000, 16'd200);
      repeat (10) @(posedge clk);
      #2 res_n = 1'b0;
      #1;
      check("midrst_busy",      32'(bus.busy),      32'd0);
      check("midrst_ready",     32'(bus.ready),     32'd0);
      check("midrst_quotient",  32'(bus.quotient),  32'd0);
      check("midrst_remainder", 32'(bus.remainder), 32'd0);
      repeat (2) @(posedge clk);
      #2 res_n = 1'b1;
      repeat (20) @(negedge clk);
      check("midrst_no_ready", 32'(bus.ready), 32'd0);
      start_op(32'd1000, 16'd200);
      wait_done(cyc, seen);
      check_result("afterrst", cyc, seen, 16, 16'd5, 16'd0, 1'b0, 1'b1);

      // back-to-back request from DONE
      start_op(32'hFFFE_0001, 16'hFFFF);
      wait_done(cyc, seen);
      check_result("maxval", cyc, seen, 16, 16'hFFFF, 16'd0, 1'b0, 1'b1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 16: divisor/quotient/remainder width; dividend is 2*WIDTH.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 res_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  enable; low freezes all internal state and outputs.
REQ-005 start  input  1  request; sampled on rising clk.
REQ-006 dividend  input  2*WIDTH  numerator; sampled only when a request is accepted.
REQ-007 divisor  input  WIDTH  denominator; sampled only when a request is accepted.
REQ-008 quotient  output  WIDTH  result, registered.
REQ-009 remainder  output  WIDTH  remainder, registered.
REQ-010 busy  output  1  operation in progress.
REQ-011 ready  output  1  quotient/remainder valid; {busy, ready} is the dividercontrol pair consumed by Speed.
REQ-012 err  output  1  result invalid: divide-by-zero, or overflow when enabled.

Function
REQ-013 Three states: IDLE, BUSY, DONE; a request is accepted when en=1, start=1 and state is IDLE or DONE.
REQ-014 On acceptance: latch operands, clear ready and err, set busy=1, enter BUSY on the same edge.
REQ-015 BUSY runs restoring division, one quotient bit per cycle, MSB first, exactly WIDTH iterations.
REQ-016 Iteration i: shift {partial remainder, dividend bits} left by 1; subtract divisor if partial remainder >= divisor (WIDTH+1-bit compare); shift result bit into quotient.
REQ-017 Latency: the request is accepted on edge 0; busy is high for exactly WIDTH cycles; on edge WIDTH, state becomes DONE with busy=0, ready=1, and quotient/remainder valid.
REQ-018 In DONE, ready, quotient, remainder and err hold until the next accepted request or reset.
REQ-019 start while BUSY is ignored; it is not queued.
REQ-020 Divisor zero on acceptance: no iterations; the next edge enters DONE with quotient all ones, remainder 0, err=1, busy=0, ready=1.
REQ-021 en low in any state holds the iteration counter, registers and outputs; the operation resumes where it stopped when en returns high.
REQ-022 Iteration counter is ceil(log2(WIDTH+1)) bits and never wraps; BUSY exits when it reaches WIDTH.
REQ-023 Operand changes after acceptance have no effect on the running operation.

Reset
REQ-024 res_n low immediately forces IDLE, quotient=0, remainder=0, busy=0, ready=0, err=0, counter=0, regardless of clk.
REQ-025 Reset during BUSY aborts the operation; no ready pulse follows the release of reset.
REQ-026 After res_n deasserts, the first request can be accepted on the first rising edge.

Configuration
REQ-027 Macro DIVIDER_OVERFLOW_CHECK_EN: when defined, acceptance with nonzero divisor and dividend[2*WIDTH-1:WIDTH] >= divisor skips iteration; the next edge gives DONE with quotient all ones (saturated), remainder 0, err=1.
REQ-028 Without DIVIDER_OVERFLOW_CHECK_EN, overflow inputs run the normal WIDTH iterations; quotient holds the low WIDTH bits, remainder is unspecified, err=0; only divide-by-zero sets err.

Verification
REQ-029 Reset, then dividend=1000, divisor=200, start pulse -> busy high 16 cycles, then ready=1, quotient=5, remainder=0, err=0.
REQ-030 dividend=73728, divisor=255 -> after 16 cycles, quotient=289, remainder=33; start pulse during BUSY is ignored and the result is unchanged.
REQ-031 divisor=0, dividend=500 -> one cycle later ready=1, quotient=16'hFFFF, remainder=0, err=1.
REQ-032 dividend=32'h0001_0000, divisor=1 -> with macro: one cycle later quotient=16'hFFFF, err=1; without macro: 16 cycles, quotient=16'h0000, err=0.
REQ-033 Drop en for 5 cycles at iteration 8 of 1000/200 -> busy high 21 cycles total; quotient=5.
REQ-034 Assert res_n low at iteration 10 -> outputs zero immediately; after release, no ready until a new start, then 1000/200 gives quotient=5.
